// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/load-store masters, the arbiter and the system memory.
// The d_lock signal exists only when MEM_PORT_ARBITER_LOCK_EN is defined.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
`ifdef MEM_PORT_ARBITER_LOCK_EN
    logic              d_lock;
`endif

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter view: requests and memory read data in, grants and memory controls out.
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
`ifdef MEM_PORT_ARBITER_LOCK_EN
        input  d_lock,
`endif
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_addr, mem_wdata, mem_read, mem_write
    );

    // Environment view: masters and memory model together.
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
`ifdef MEM_PORT_ARBITER_LOCK_EN
        output d_lock,
`endif
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_addr, mem_wdata, mem_read, mem_write
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port memory between fetch (I) and load/store (D).
// Define MEM_PORT_ARBITER_LOCK_EN to add d_lock for back-to-back locked D accesses.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_I = 2'd1,
        ST_SERVE_D = 2'd2
    } state_e;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

    state_e            state_q, state_d;
    port_e             last_q, last_d;
    logic              i_gnt_q, i_gnt_d;
    logic              d_gnt_q, d_gnt_d;
    logic              i_rvalid_q, i_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;

    // Next-state selection and read-data capture for the port served this cycle.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        i_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_req && bus.d_req) begin
                    if (last_q == PORT_D) begin
                        state_d = ST_SERVE_I;
                    end else begin
                        state_d = ST_SERVE_D;
                    end
                end else if (bus.i_req) begin
                    state_d = ST_SERVE_I;
                end else if (bus.d_req) begin
                    state_d = ST_SERVE_D;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVE_I: begin
                i_rdata_d  = bus.mem_rdata;
                i_rvalid_d = 1'b1;
                last_d     = PORT_I;
                if (bus.d_req) begin
                    state_d = ST_SERVE_D;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVE_D: begin
                // A completed write reports zero so stale load data never leaks out.
                if (mem_write_q) begin
                    d_rdata_d = {DATA_W{1'b0}};
                end else begin
                    d_rdata_d = bus.mem_rdata;
                end
                d_rvalid_d = 1'b1;
                last_d     = PORT_D;
`ifdef MEM_PORT_ARBITER_LOCK_EN
                if (bus.d_lock && bus.d_req) begin
                    state_d = ST_SERVE_D;
                end else if (bus.i_req) begin
                    state_d = ST_SERVE_I;
                end else begin
                    state_d = ST_IDLE;
                end
`else
                if (bus.i_req) begin
                    state_d = ST_SERVE_I;
                end else begin
                    state_d = ST_IDLE;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Grant and memory controls follow the upcoming state so they are flop outputs during it.
    always_comb begin
        i_gnt_d     = 1'b0;
        d_gnt_d     = 1'b0;
        mem_addr_d  = {ADDR_W{1'b0}};
        mem_wdata_d = {DATA_W{1'b0}};
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        case (state_d)
            ST_SERVE_I: begin
                i_gnt_d    = 1'b1;
                mem_addr_d = bus.i_addr;
                mem_read_d = 1'b1;
            end
            ST_SERVE_D: begin
                d_gnt_d     = 1'b1;
                mem_addr_d  = bus.d_addr;
                mem_wdata_d = bus.d_wdata;
                mem_read_d  = ~bus.d_we;
                mem_write_d = bus.d_we;
            end
            default: begin
                i_gnt_d = 1'b0;
            end
        endcase
    end

    // Sequencer state and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_q      <= PORT_D;
            i_gnt_q     <= 1'b0;
            d_gnt_q     <= 1'b0;
            i_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
            i_rdata_q   <= {DATA_W{1'b0}};
            d_rdata_q   <= {DATA_W{1'b0}};
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            i_gnt_q     <= i_gnt_d;
            d_gnt_q     <= d_gnt_d;
            i_rvalid_q  <= i_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    assign bus.i_gnt     = i_gnt_q;
    assign bus.d_gnt     = d_gnt_q;
    assign bus.i_rvalid  = i_rvalid_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic checked
// against a grant-rule and memory-contents reference model.
module tb_mem_port_arbiter;
    logic clk;
    logic rst_n;
    logic mem_clr;
    int   total;
    int   bad;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // System memory: combinational read, write on the rising edge.
    logic [31:0] sys_mem [0:255];
    assign bus.mem_rdata = sys_mem[bus.mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int k = 0; k < 256; k++) sys_mem[k] <= 32'd0;
        end else if (bus.mem_write) begin
            sys_mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
        end
    end

    // Master request state and reference model
    logic        i_pend, d_pend, d_w, lk;
    logic [31:0] i_a, d_a, d_wd;
    logic [31:0] ref_mem [0:255];
    logic        prev_gi, prev_gd, last_is_d;
    logic [31:0] exp_i, exp_d;
    int          i_age, d_age;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic apply();
        bus.i_req   = i_pend;
        bus.i_addr  = i_a;
        bus.d_req   = d_pend;
        bus.d_we    = d_w;
        bus.d_addr  = d_a;
        bus.d_wdata = d_wd;
`ifdef MEM_PORT_ARBITER_LOCK_EN
        bus.d_lock  = lk;
`endif
    endtask

    task automatic model_reset();
        prev_gi   = 1'b0;
        prev_gd   = 1'b0;
        last_is_d = 1'b1;
        i_age     = 0;
        d_age     = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {26'd0, bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid,
                            bus.mem_read, bus.mem_write}, 32'd0);
        chk({tag, "_i_rdata"}, bus.i_rdata, 32'd0);
        chk({tag, "_d_rdata"}, bus.d_rdata, 32'd0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    endtask

    // One clock: check everything visible this cycle against the rules, then advance the masters.
    task automatic step();
        logic gi, gd, e_gi, e_gd;
        @(negedge clk);
        gi = bus.i_gnt;
        gd = bus.d_gnt;
        if (prev_gi) begin
            e_gi = 1'b0;
            e_gd = d_pend;
        end else if (prev_gd) begin
            if (lk && d_pend) begin
                e_gi = 1'b0;
                e_gd = 1'b1;
            end else begin
                e_gi = i_pend;
                e_gd = 1'b0;
            end
        end else if (i_pend && d_pend) begin
            e_gi = last_is_d;
            e_gd = ~last_is_d;
        end else begin
            e_gi = i_pend;
            e_gd = d_pend;
        end
        chk1("i_gnt", gi, e_gi);
        chk1("d_gnt", gd, e_gd);
        chk1("rw_exclusive", bus.mem_read & bus.mem_write, 1'b0);
        chk1("i_rvalid", bus.i_rvalid, prev_gi);
        chk1("d_rvalid", bus.d_rvalid, prev_gd);
        if (prev_gi) chk("i_rdata", bus.i_rdata, exp_i);
        if (prev_gd) chk("d_rdata", bus.d_rdata, exp_d);
        if (gi) begin
            chk("i_mem_addr", bus.mem_addr, i_a);
            chk("i_mem_wdata", bus.mem_wdata, 32'd0);
            chk1("i_mem_read", bus.mem_read, 1'b1);
            chk1("i_mem_write", bus.mem_write, 1'b0);
            exp_i     = ref_mem[i_a[9:2]];
            last_is_d = 1'b0;
        end else if (gd) begin
            chk("d_mem_addr", bus.mem_addr, d_a);
            chk("d_mem_wdata", bus.mem_wdata, d_wd);
            chk1("d_mem_read", bus.mem_read, ~d_w);
            chk1("d_mem_write", bus.mem_write, d_w);
            if (d_w) begin
                ref_mem[d_a[9:2]] = d_wd;
                exp_d = 32'd0;
            end else begin
                exp_d = ref_mem[d_a[9:2]];
            end
            last_is_d = 1'b1;
        end else begin
            chk("idle_mem_ctl", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
            chk("idle_mem_addr", bus.mem_addr, 32'd0);
            chk("idle_mem_wdata", bus.mem_wdata, 32'd0);
        end
        if (i_pend && !gi) i_age++; else i_age = 0;
        if (d_pend && !gd) d_age++; else d_age = 0;
        chk1("i_wait_bound", (i_age <= 4), 1'b1);
        chk1("d_wait_bound", (d_age <= 4), 1'b1);
        if (gi) i_pend = 1'b0;
        if (gd) d_pend = 1'b0;
        prev_gi = gi;
        prev_gd = gd;
        apply();
    endtask

    task automatic d_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd);
        d_pend = 1'b1; d_w = we; d_a = a; d_wd = wd;
        apply();
        step();
        chk1("d_gnt_latency", bus.d_gnt, 1'b1);
        step();
        chk1("d_rvalid_latency", bus.d_rvalid, 1'b1);
        chk1("d_write_one_cycle", bus.mem_write, 1'b0);
        rd = bus.d_rdata;
    endtask

    task automatic i_txn(input logic [31:0] a, output logic [31:0] rd);
        i_pend = 1'b1; i_a = a;
        apply();
        step();
        chk1("i_gnt_latency", bus.i_gnt, 1'b1);
        step();
        chk1("i_rvalid_latency", bus.i_rvalid, 1'b1);
        rd = bus.i_rdata;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a      = $urandom();
        a[9:2] = 8'($urandom_range(0, 7));
        return a;
    endfunction

    initial begin
        logic [31:0] rd;
        total = 0; bad = 0;
        i_pend = 1'b0; d_pend = 1'b0; d_w = 1'b0; lk = 1'b0;
        i_a = 32'd0; d_a = 32'd0; d_wd = 32'd0;
        exp_i = 32'd0; exp_d = 32'd0;
        for (int k = 0; k < 256; k++) ref_mem[k] = 32'd0;
        model_reset();
        apply();
        rst_n = 1'b0; mem_clr = 1'b1;
        repeat (3) @(posedge clk);
        mem_clr = 1'b0;
        @(negedge clk);
        chk_all_zero("reset");

        // Contention straight out of reset: I first, then strict alternation.
        i_pend = 1'b1; i_a = 32'h0000_0000;
        d_pend = 1'b1; d_w = 1'b0; d_a = 32'h0000_0020; d_wd = 32'd0;
        rst_n = 1'b1;
        apply();
        for (int k = 0; k < 8; k++) begin
            step();
            chk1("cont_i_order", bus.i_gnt, (k % 2) == 0);
            chk1("cont_d_order", bus.d_gnt, (k % 2) == 1);
            if (!i_pend) i_pend = 1'b1;
            if (!d_pend) d_pend = 1'b1;
            apply();
        end
        repeat (3) step();

        // Fetch of freshly stored data.
        d_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, rd);
        chk("fetch_store_rdata", rd, 32'd0);
        i_txn(32'h0000_0010, rd);
        chk("fetch_data", rd, 32'hDEAD_BEEF);

        // Store to the top word, then read it back.
        d_txn(1'b1, 32'h0000_03FC, 32'h1234_5678, rd);
        chk("store_rdata_zero", rd, 32'd0);
        d_txn(1'b0, 32'h0000_03FC, 32'd0, rd);
        chk("store_readback", rd, 32'h1234_5678);

        // Index bits wrap: 0x400 aliases 0x000.
        d_txn(1'b1, 32'h0000_0000, 32'hA5A5_A5A5, rd);
        d_txn(1'b0, 32'h0000_0400, 32'd0, rd);
        chk("wrap_read", rd, 32'hA5A5_A5A5);

        // Reset during a fetch grant drops it without a valid.
        i_pend = 1'b1; i_a = 32'h0000_0010;
        apply();
        step();
        chk1("rst_mid_gnt_before", bus.i_gnt, 1'b1);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("rst_mid");
        i_pend = 1'b0;
        apply();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step();
        chk1("rst_no_rvalid", bus.i_rvalid, 1'b0);
        chk("rst_i_rdata", bus.i_rdata, 32'd0);

`ifdef MEM_PORT_ARBITER_LOCK_EN
        // Three locked D accesses back to back while I waits, then I.
        lk = 1'b1; d_pend = 1'b1; d_w = 1'b0; d_a = 32'h0000_0010;
        apply();
        for (int k = 0; k < 3; k++) begin
            step();
            chk1("lock_d_run", bus.d_gnt, 1'b1);
            if (k == 0) begin i_pend = 1'b1; i_a = 32'h0000_03FC; end
            if (k < 2) begin
                d_pend = 1'b1; d_a = 32'h0000_0010 + 32'(k * 4);
            end else begin
                lk = 1'b0;
            end
            apply();
        end
        step();
        chk1("lock_then_i", bus.i_gnt, 1'b1);
        repeat (2) step();
`endif

        // Random traffic on both ports.
        lk = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1'b1;
                i_a    = rand_addr();
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1'b1;
                d_w    = 1'($urandom_range(0, 1));
                d_a    = rand_addr();
                d_wd   = $urandom();
            end
            apply();
            step();
        end
        repeat (6) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
